// File: rtl/trackball_step_gen.sv
// Turns joystick directions and mouse deltas into Atari-style quadrature-ish trackball lines (dir + clock per axis).
// Latency: an edge on the first step tick after motion registers; a direction reversal delays that edge by one extra tick.
// No backpressure: inputs are accepted every cycle and pending motion saturates at +/-(2^(ACC_W-1)-1).
module trackball_step_gen #(
    parameter int STEP_DIV = 1000,
    parameter int JOY_DIV  = 4,
    parameter int ACC_W    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       joy_up,
    input  logic       joy_down,
    input  logic       joy_left,
    input  logic       joy_right,
    input  logic [8:0] mouse_dx,
    input  logic [8:0] mouse_dy,
    input  logic       mouse_strobe,
    output logic       tb_hd,
    output logic       tb_hc,
    output logic       tb_vd,
    output logic       tb_vc
);
    localparam int CNT_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int JCNT_W = (JOY_DIV > 1) ? $clog2(JOY_DIV) : 1;
    localparam int SUM_W  = ACC_W + 2;
    localparam logic signed [SUM_W-1:0] ONE     = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;

    typedef enum logic {
        IDLE  = 1'b0,
        SETUP = 1'b1
    } state_t;

    // Axis index 0 is horizontal, 1 is vertical.
    logic [CNT_W-1:0]        step_cnt;
    logic [JCNT_W-1:0]       jcount;
    logic                    tick;
    logic                    jtick;
    state_t                  state_q [2];
    state_t                  state_d [2];
    logic signed [ACC_W-1:0] acc_q [2];
    logic signed [ACC_W-1:0] acc_d [2];
    logic [1:0]              dir_q, dir_d;
    logic [1:0]              clk_q, clk_d;
    logic signed [SUM_W-1:0] joy_t [2];
    logic signed [SUM_W-1:0] mouse_t [2];

    assign tick  = (step_cnt == CNT_W'(STEP_DIV - 1));
    assign jtick = tick && (jcount == JCNT_W'(JOY_DIV - 1));

    // Free-running step tick divider and the slower joystick repeat divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt <= '0;
            jcount   <= '0;
        end else begin
            step_cnt <= tick ? '0 : step_cnt + CNT_W'(1);
            if (tick) begin
                jcount <= jtick ? '0 : jcount + JCNT_W'(1);
            end
        end
    end

    // Per-axis motion contributions for this cycle; opposing joystick directions cancel.
    always_comb begin
        joy_t[0] = '0;
        joy_t[1] = '0;
        if (jtick) begin
            if (joy_right && !joy_left) joy_t[0] = ONE;
            else if (joy_left && !joy_right) joy_t[0] = -ONE;
            if (joy_down && !joy_up) joy_t[1] = ONE;
            else if (joy_up && !joy_down) joy_t[1] = -ONE;
        end
        mouse_t[0] = mouse_strobe ? SUM_W'($signed(mouse_dx)) : '0;
        mouse_t[1] = mouse_strobe ? SUM_W'($signed(mouse_dy)) : '0;
    end

    // Axis FSMs and accumulator update; a direction change never shares a cycle with a clock edge.
    always_comb begin
        logic                    step_edge;
        logic                    acc_nz;
        logic                    acc_pos;
        logic signed [SUM_W-1:0] consume;
        logic signed [SUM_W-1:0] sum;
        dir_d = dir_q;
        clk_d = clk_q;
        for (int a = 0; a < 2; a++) begin
            state_d[a] = state_q[a];
            acc_d[a]   = acc_q[a];
            step_edge  = 1'b0;
            consume    = '0;
            acc_nz     = (acc_q[a] != '0);
            acc_pos    = acc_nz && !acc_q[a][ACC_W-1];
            if (tick) begin
                case (state_q[a])
                    IDLE: begin
                        if (acc_nz) begin
                            if (acc_pos == dir_q[a]) begin
                                step_edge = 1'b1;
                            end else begin
                                dir_d[a]   = acc_pos;
                                state_d[a] = SETUP;
                            end
                        end
                    end
                    SETUP: begin
                        // Motion that vanished or flipped sign while turning around takes no edge here.
                        state_d[a] = IDLE;
                        if (acc_nz && (acc_pos == dir_q[a])) step_edge = 1'b1;
                    end
                    default: state_d[a] = IDLE;
                endcase
            end
            if (step_edge) begin
                clk_d[a] = ~clk_q[a];
                consume  = acc_pos ? ONE : -ONE;
            end
            sum = SUM_W'(acc_q[a]) + joy_t[a] + mouse_t[a] - consume;
            if (sum > ACC_MAX) acc_d[a] = ACC_MAX[ACC_W-1:0];
            else if (sum < ACC_MIN) acc_d[a] = ACC_MIN[ACC_W-1:0];
            else acc_d[a] = sum[ACC_W-1:0];
        end
    end

    // State, accumulator and registered output lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 2; a++) begin
                state_q[a] <= IDLE;
                acc_q[a]   <= '0;
            end
            dir_q <= '0;
            clk_q <= '0;
        end else begin
            for (int a = 0; a < 2; a++) begin
                state_q[a] <= state_d[a];
                acc_q[a]   <= acc_d[a];
            end
            dir_q <= dir_d;
            clk_q <= clk_d;
        end
    end

    assign tb_hd = dir_q[0];
    assign tb_hc = clk_q[0];
    assign tb_vd = dir_q[1];
    assign tb_vc = clk_q[1];
endmodule

// File: tb/tb_trackball_step_gen.sv
// Bench for trackball_step_gen: randomized and directed motion against a tick-level reference model.
// Expected output changes are queued with their cycle; a monitor pops them whenever DUT outputs change.
// Directed phases also check toggle counts and levels taken straight from the intended behaviour.
module tb_trackball_step_gen;
    localparam int SD   = 4;
    localparam int JD   = 4;
    localparam int AMAX = 511;

    logic       clk = 1'b0;
    logic       reset;
    logic       joy_up, joy_down, joy_left, joy_right;
    logic [8:0] mouse_dx, mouse_dy;
    logic       mouse_strobe;
    logic       tb_hd, tb_hc, tb_vd, tb_vc;

    trackball_step_gen #(.STEP_DIV(SD), .JOY_DIV(JD), .ACC_W(10)) dut (
        .clk(clk), .reset(reset),
        .joy_up(joy_up), .joy_down(joy_down), .joy_left(joy_left), .joy_right(joy_right),
        .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_strobe(mouse_strobe),
        .tb_hd(tb_hd), .tb_hc(tb_hc), .tb_vd(tb_vd), .tb_vc(tb_vc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } ev_t;

    ev_t  q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   hc_tog = 0;
    int   vc_tog = 0;
    bit   mon_en = 0;
    logic rst_at_edge = 1'b0;
    logic [3:0] cur, prev;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pending motion per axis as plain integers, updated once per clock edge.
    int       m_cnt = 0, m_jcnt = 0;
    int       m_acc [2] = '{0, 0};
    bit       m_dir [2] = '{0, 0};
    bit       m_clk [2] = '{0, 0};
    bit       m_turn [2] = '{0, 0};
    logic [3:0] m_out = 4'b0;

    task automatic model_step();
        bit tick, jtick, edge_now;
        int j [2];
        int m [2];
        int c, s;
        logic [3:0] o;
        if (reset) begin
            m_cnt = 0; m_jcnt = 0;
            for (int a = 0; a < 2; a++) begin
                m_acc[a] = 0; m_dir[a] = 0; m_clk[a] = 0; m_turn[a] = 0;
            end
        end else begin
            tick  = (m_cnt == SD - 1);
            jtick = tick && (m_jcnt == JD - 1);
            j[0] = jtick ? (int'(joy_right) - int'(joy_left)) : 0;
            j[1] = jtick ? (int'(joy_down) - int'(joy_up)) : 0;
            m[0] = mouse_strobe ? int'($signed(mouse_dx)) : 0;
            m[1] = mouse_strobe ? int'($signed(mouse_dy)) : 0;
            for (int a = 0; a < 2; a++) begin
                edge_now = 0;
                if (tick) begin
                    if (m_acc[a] != 0 && ((m_acc[a] > 0) == m_dir[a])) begin
                        edge_now  = 1;
                        m_turn[a] = 0;
                    end else if (m_acc[a] != 0 && !m_turn[a]) begin
                        m_dir[a]  = (m_acc[a] > 0);
                        m_turn[a] = 1;
                    end else begin
                        m_turn[a] = 0;
                    end
                end
                c = edge_now ? ((m_acc[a] > 0) ? 1 : -1) : 0;
                if (edge_now) m_clk[a] = !m_clk[a];
                s = m_acc[a] + j[a] + m[a] - c;
                m_acc[a] = (s > AMAX) ? AMAX : ((s < -AMAX) ? -AMAX : s);
            end
            m_cnt = (m_cnt + 1) % SD;
            if (tick) m_jcnt = (m_jcnt + 1) % JD;
        end
        o = {m_dir[0], m_clk[0], m_dir[1], m_clk[1]};
        if (o != m_out) q.push_back('{cyc + 1, o});
        m_out = o;
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobe(input logic [8:0] dx, input logic [8:0] dy);
        mouse_dx = dx; mouse_dy = dy; mouse_strobe = 1'b1;
        step();
        mouse_strobe = 1'b0; mouse_dx = '0; mouse_dy = '0;
    endtask

    // Monitor: any change on the output lines must match the next queued expectation.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {tb_hd, tb_hc, tb_vd, tb_vc};
                if (cur !== prev) begin
                    if (cur[2] !== prev[2]) hc_tog++;
                    if (cur[0] !== prev[0]) vc_tog++;
                    if (!rst_at_edge) begin
                        if (cur[3] !== prev[3]) chk("h_dir_change_without_edge", int'(cur[2] ^ prev[2]), 0);
                        if (cur[1] !== prev[1]) chk("v_dir_change_without_edge", int'(cur[0] ^ prev[0]), 0);
                    end
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_change: outputs %b, none expected (cycle %0d)", cur, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("event_cycle", cyc, e.cyc);
                        chk("event_outputs", int'(cur), int'(e.v));
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        int h0, v0;
        reset = 1'b1;
        {joy_up, joy_down, joy_left, joy_right} = 4'b0;
        mouse_dx = '0; mouse_dy = '0; mouse_strobe = 1'b0;
        @(negedge clk);
        #1;
        run(3);
        reset = 1'b0;
        chk("reset_outputs", int'({tb_hd, tb_hc, tb_vd, tb_vc}), 0);
        prev   = {tb_hd, tb_hc, tb_vd, tb_vc};
        mon_en = 1;

        // +3 from reset: one turnaround tick, then three horizontal edges.
        h0 = hc_tog; v0 = vc_tog;
        strobe(9'd3, 9'd0);
        run(32);
        chk("dx3_hc_toggles", hc_tog - h0, 3);
        chk("dx3_hd", int'(tb_hd), 1);
        chk("dx3_vc_quiet", vc_tog - v0, 0);

        // -2: reversal then two edges.
        h0 = hc_tog;
        strobe(9'h1FE, 9'd0);
        run(32);
        chk("dxm2_hc_toggles", hc_tog - h0, 2);
        chk("dxm2_hd", int'(tb_hd), 0);

        // Joystick right held, then both held cancels.
        joy_right = 1'b1;
        run(80);
        chk("joy_right_hd", int'(tb_hd), 1);
        joy_left = 1'b1;
        run(40);
        h0 = hc_tog;
        run(48);
        chk("joy_both_no_toggles", hc_tog - h0, 0);
        {joy_left, joy_right} = 2'b0;
        run(40);

        // Vertical saturation: 3 x 255 clamps to 511 pending steps.
        v0 = vc_tog;
        strobe(9'd0, 9'd255);
        strobe(9'd0, 9'd255);
        strobe(9'd0, 9'd255);
        run((AMAX + 4) * SD + 16);
        chk("sat_vc_toggles", vc_tog - v0, AMAX);
        chk("sat_vd", int'(tb_vd), 1);

        // Reset in the middle of a long horizontal burst discards it.
        strobe(9'd100, 9'd0);
        run(21);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_outputs", int'({tb_hd, tb_hc, tb_vd, tb_vc}), 0);
        h0 = hc_tog; v0 = vc_tog;
        run(60);
        chk("midreset_no_hc", hc_tog - h0, 0);
        chk("midreset_no_vc", vc_tog - v0, 0);

        // Random mix of strobes and joystick, including coincident strobe/jtick/edge cycles.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) {joy_up, joy_down, joy_left, joy_right} = 4'($urandom);
            if ($urandom_range(0, 11) == 0) begin
                mouse_strobe = 1'b1;
                mouse_dx = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($signed($urandom_range(0, 12)) - 6);
                mouse_dy = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($signed($urandom_range(0, 12)) - 6);
            end else begin
                mouse_strobe = 1'b0;
            end
            step();
        end
        mouse_strobe = 1'b0;
        {joy_up, joy_down, joy_left, joy_right} = 4'b0;
        run(20);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trackball_step_gen.md
Name: trackball_step_gen

Overview:
- Upstream feeder for the trackball counter inputs tb1HD/tb1HC/tb1VD/tb1VC on the Crystal Castles core.
- Converts joystick directions and relative mouse deltas into Atari-style trackball signals.
- Each axis produces a direction level plus a clock line, toggled once per motion step.
- Runs in the 10 MHz core clock domain; outputs connect directly to the core's trackball pins.

Parameters:
- STEP_DIV, 1000, core clocks per step tick (maximum edge rate per axis = clk/STEP_DIV).
- JOY_DIV, 4, step ticks between joystick-generated unit moves.
- ACC_W, 10, width of the signed per-axis pending-motion accumulator.

Ports:
- clk  in  1  core clock, 10 MHz
- reset  in  1  synchronous, active-high
- joy_up  in  1  joystick up, active-high
- joy_down  in  1  joystick down, active-high
- joy_left  in  1  joystick left, active-high
- joy_right  in  1  joystick right, active-high
- mouse_dx  in  9  signed horizontal delta, two's complement
- mouse_dy  in  9  signed vertical delta, two's complement
- mouse_strobe  in  1  one-clk pulse; deltas valid this cycle
- tb_hd  out  1  horizontal direction, 1 = positive
- tb_hc  out  1  horizontal clock, toggles once per step
- tb_vd  out  1  vertical direction, 1 = positive
- tb_vc  out  1  vertical clock, toggles once per step

Behaviour:
- Clock and reset are decided: one clock `clk`; reset `reset` is synchronous and active-high.
- While `reset` is high, at the next clk edge:
  - all outputs go to 0;
  - both accumulators, step counter and joystick counter go to 0;
  - both FSMs go to IDLE.
  - Pending motion is discarded if reset arrives mid-operation.
- Step counter:
  - counts 0..STEP_DIV-1 and wraps;
  - `tick` is a one-clk pulse in the cycle the count equals STEP_DIV-1.
- Joystick counter:
  - advances on `tick` and wraps at JOY_DIV-1;
  - `jtick` = tick AND (jcount == JOY_DIV-1).
- Joystick contribution, on `jtick` only:
  - H: right&~left → +1; left&~right → -1; both or neither → 0.
  - V: down&~up → +1; up&~down → -1; both or neither → 0.
- Mouse contribution: on mouse_strobe, mouse_dx and mouse_dy are sign-extended to ACC_W and added.
- Accumulator update, per axis, single cycle:
  - acc_next = sat(acc + joy + mouse - consume).
  - `consume` is +1 or -1 when the FSM emits a clock edge this cycle (moves acc toward 0), else 0.
  - All terms sum in one cycle; none is lost on simultaneous events.
  - sat clamps to ±(2^(ACC_W-1)-1), i.e. ±511 at default.
  - The most negative code is never stored.
- Axis FSM, evaluated only on `tick`; outputs registered:
  - IDLE:
    - acc == 0 → stay in IDLE.
    - acc != 0 and sign(acc) matches current direction output (dir=1 for acc>0) → toggle clock output, consume 1, stay in IDLE.
    - acc != 0 and sign differs → set direction output to the new sign, go to SETUP; no clock edge this tick.
  - SETUP: on the next tick, toggle clock output, consume 1, return to IDLE.
  - Direction therefore has at least STEP_DIV clk of setup before a clock edge after any reversal.
  - Direction is never changed in the same cycle as a clock edge.
- Clock edges:
  - At most one clock edge per axis per tick.
  - H and V axes are independent and may toggle in the same cycle.
  - Clock output level is free-running; no return-to-zero.
  - A direction output holds its last value when idle.
- Latency:
  - acc nonzero with matching direction: edge on the first tick after the update registers.
  - Reversal: edge on the second tick.
- Mouse during SETUP:
  - If acc returns to 0, the SETUP tick emits no edge and no consume, and the FSM returns to IDLE.
  - If acc changes sign during SETUP, the FSM goes back through IDLE (direction update first).

Test Plan:
- Reset, then mouse_dx=+3 strobe, STEP_DIV=4: tb_hd=1 set on the first tick with no edge (SETUP, since direction reset is 0). tb_hc then toggles 3 times on ticks 2, 3, 4. acc_h=0 afterwards; tb_vc stays constant.
- Continue with mouse_dx=-2: tb_hd→0 on the next tick with no edge. Then 2 tb_hc toggles on consecutive ticks; no edge coincides with the tb_hd change.
- joy_right held, JOY_DIV=4: one tb_hc toggle per 4 ticks, tb_hd=1. joy_left+joy_right both held: no further toggles after the pending count drains.
- Saturation: 3 strobes of mouse_dy=+255 give acc_v=511, not 765. Exactly 511 tb_vc toggles follow (one reversal SETUP tick first, since direction reset is 0), then idle.
- Simultaneous events: mouse_strobe on the same cycle as jtick and a consume edge, with acc=5, dx=+2, joy=+1, consume=1 → acc=7.
- Reset asserted with acc_h=100 mid-stream: next cycle all outputs 0 and acc 0; no further toggles after reset releases.
